// File: rtl/booth2_pkg.sv
// Constants and types shared by the radix-4 Booth 16x16 multiplier blocks
// (encoder, Wallace reduction and the sequential accumulator).
package booth2_pkg;

    localparam int PP_NUM = 8;
    localparam int PP_W   = 17;
    localparam int PROD_W = 32;
    localparam int IDX_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    typedef logic [PP_W-1:0]   pp_t;
    typedef logic [PROD_W-1:0] prod_t;
    typedef logic [IDX_W-1:0]  idx_t;

endpackage

// File: rtl/booth2_pp_accum_if.sv
// Handshake bundle for the Booth partial-product accumulator: one input set
// of eight partial products, one 32-bit product output.
interface booth2_pp_accum_if;
    import booth2_pkg::*;

    logic  in_valid;
    logic  in_ready;
    pp_t   PP1;
    pp_t   PP2;
    pp_t   PP3;
    pp_t   PP4;
    pp_t   PP5;
    pp_t   PP6;
    pp_t   PP7;
    pp_t   PP8;
    logic  out_valid;
    logic  out_ready;
    prod_t out_product;

    modport master (
        output in_valid, PP1, PP2, PP3, PP4, PP5, PP6, PP7, PP8, out_ready,
        input  in_ready, out_valid, out_product
    );

    modport slave (
        input  in_valid, PP1, PP2, PP3, PP4, PP5, PP6, PP7, PP8, out_ready,
        output in_ready, out_valid, out_product
    );

endinterface

// File: rtl/booth2_pp_align.sv
// Places one Booth partial product at its radix-4 weight:
// sign-extend to product width, then shift left by 2*idx (high bits drop).
module booth2_pp_align
    import booth2_pkg::*;
(
    input  pp_t   pp,
    input  idx_t  idx,
    output prod_t term
);

    prod_t sext;

    assign sext = {{(PROD_W-PP_W){pp[PP_W-1]}}, pp};
    assign term = sext << {idx, 1'b0};

endmodule

// File: rtl/booth2_pp_accum.sv
// Multi-cycle partial-product accumulator: captures eight Booth PPs in one
// handshake, then adds one weighted PP per cycle into a 32-bit product.
module booth2_pp_accum
    import booth2_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    booth2_pp_accum_if.slave  bus
);

    state_t state;
    idx_t   idx;
    prod_t  acc;
    pp_t    pp_reg [PP_NUM];
    logic   out_valid_q;
    prod_t  out_product_q;

    pp_t    pp_sel;
    prod_t  term;
    prod_t  acc_next;

    assign pp_sel   = pp_reg[idx];
    assign acc_next = acc + term;

    booth2_pp_align u_align (
        .pp   (pp_sel),
        .idx  (idx),
        .term (term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            acc           <= '0;
            pp_reg        <= '{default: '0};
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        pp_reg[0] <= bus.PP1;
                        pp_reg[1] <= bus.PP2;
                        pp_reg[2] <= bus.PP3;
                        pp_reg[3] <= bus.PP4;
                        pp_reg[4] <= bus.PP5;
                        pp_reg[5] <= bus.PP6;
                        pp_reg[6] <= bus.PP7;
                        pp_reg[7] <= bus.PP8;
                        acc       <= '0;
                        idx       <= '0;
                        state     <= ACC;
                    end
                end
                ACC: begin
                    acc <= acc_next;
                    // idx holds at its last value; leaving ACC ends the sweep
                    if (idx == idx_t'(PP_NUM - 1)) begin
                        state         <= DONE;
                        out_valid_q   <= 1'b1;
                        out_product_q <= acc_next;
                    end else begin
                        idx <= idx + idx_t'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gated by rst so a reset cycle never advertises readiness
    assign bus.in_ready    = (state == IDLE) && !rst;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_product = out_product_q;

endmodule

// File: tb/tb_booth2_pp_accum.sv
// Directed and soak bench for booth2_pp_accum; expected products come from
// hand-computed constants and an independent Booth encoding of A and B.
module tb_booth2_pp_accum;
    import booth2_pkg::*;

    typedef logic [16:0] pp_arr_t [8];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    booth2_pp_accum_if bus();

    booth2_pp_accum dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pps(input pp_arr_t p);
        bus.PP1 = p[0];
        bus.PP2 = p[1];
        bus.PP3 = p[2];
        bus.PP4 = p[3];
        bus.PP5 = p[4];
        bus.PP6 = p[5];
        bus.PP7 = p[6];
        bus.PP8 = p[7];
    endtask

    task automatic scramble_pps();
        pp_arr_t r;
        for (int i = 0; i < 8; i++) r[i] = 17'($urandom);
        drive_pps(r);
    endtask

    // Radix-4 Booth recoding of B; PPi = digit_i * A as 17-bit two's complement
    task automatic booth_pps(input logic [15:0] a, input logic [15:0] b, output pp_arr_t p);
        logic [16:0] bx;
        int d;
        int v;
        bx = {b, 1'b0};
        for (int i = 0; i < 8; i++) begin
            d = -2 * int'(bx[2*i+2]) + int'(bx[2*i+1]) + int'(bx[2*i]);
            v = d * int'($signed(a));
            p[i] = v[16:0];
        end
    endtask

    // Presents a PP set and returns once the accept edge has passed
    task automatic accept(input pp_arr_t p, output bit ok);
        drive_pps(p);
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        scramble_pps();
        tick(); tick(); tick();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_product !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b prod=%h exp valid=0 prod=00000000",
                     bus.out_valid, bus.out_product);
        end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_in_ready got=%b exp=1", bus.in_ready);
        end
    endtask

    // One transaction with out_ready=1; checks latency, product and return to idle
    task automatic run_directed(input string name, input pp_arr_t p, input logic [31:0] exp);
        bit ok;
        int lat;
        bus.out_ready = 1'b1;
        accept(p, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_accept got in_ready=0 exp in_ready=1", name);
        end
        scramble_pps();
        wait_valid(lat);
        checks++;
        if (lat !== 8) begin
            failures++;
            $display("FAIL %s_latency got=%0d exp=8", name, lat);
        end
        checks++;
        if (bus.out_product !== exp) begin
            failures++;
            $display("FAIL %s_product got=%h exp=%h", name, bus.out_product, exp);
        end
        tick();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_return got in_ready=%b out_valid=%b exp in_ready=1 out_valid=0",
                     name, bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_basic();
        pp_arr_t p = '{default: '0};
        p[0] = 17'h00003;
        p[1] = 17'h00003;
        run_directed("a3_b5", p, 32'h0000000F);
    endtask

    task automatic test_negative();
        pp_arr_t p = '{default: '0};
        p[0] = 17'h00002;
        p[1] = 17'h1FFFF;
        run_directed("am1_b2", p, 32'hFFFFFFFE);
    endtask

    task automatic test_sign_ext();
        pp_arr_t p = '{default: 17'h10000};
        run_directed("all_min", p, 32'hAAAB0000);
    endtask

    task automatic test_backpressure();
        pp_arr_t p;
        bit ok;
        int lat;
        int bad_hold = 0;
        logic [31:0] exp;
        booth_pps(16'd1234, 16'hFDC9, p);      // 1234 * -567
        exp = 32'hFFF552E2;                    // -699678
        bus.out_ready = 1'b0;
        accept(p, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_accept got in_ready=0 exp in_ready=1");
        end
        wait_valid(lat);
        checks++;
        if (lat !== 8 || bus.out_product !== exp) begin
            failures++;
            $display("FAIL bp_first got lat=%0d prod=%h exp lat=8 prod=%h", lat, bus.out_product, exp);
        end
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = k[0];
            scramble_pps();
            tick();
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_product !== exp)
                bad_hold++;
        end
        checks++;
        if (bad_hold != 0) begin
            failures++;
            $display("FAIL bp_hold got bad_cycles=%0d exp bad_cycles=0", bad_hold);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got in_ready=%b out_valid=%b exp in_ready=1 out_valid=0",
                     bus.in_ready, bus.out_valid);
        end
        tick();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_no_second got in_ready=%b out_valid=%b exp in_ready=1 out_valid=0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        pp_arr_t p = '{default: 17'h0ABCD};
        bit ok;
        bus.out_ready = 1'b1;
        accept(p, ok);
        tick(); tick(); tick(); tick();        // idx has reached 4
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_in_ready_during got=%b exp=0", bus.in_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_after got out_valid=%b in_ready=%b exp out_valid=0 in_ready=1",
                     bus.out_valid, bus.in_ready);
        end
        test_basic();
    endtask

    task automatic test_soak();
        pp_arr_t p;
        bit ok;
        bit done;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
        int bad = 0;
        int first_bad = -1;
        for (int t = 0; t < 1000; t++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            exp = 32'($signed(a) * $signed(b));
            booth_pps(a, b, p);
            bus.out_ready = 1'($urandom_range(0, 1));
            accept(p, ok);
            scramble_pps();
            done = 1'b0;
            for (int k = 0; k < 60 && ok; k++) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                if (bus.out_valid && bus.out_ready) begin
                    if (bus.out_product !== exp) begin
                        bad++;
                        if (first_bad < 0) begin
                            first_bad = t;
                            $display("FAIL soak_product t=%0d a=%h b=%h got=%h exp=%h",
                                     t, a, b, bus.out_product, exp);
                        end
                    end
                    done = 1'b1;
                    tick();
                    break;
                end
                tick();
            end
            checks++;
            if (!ok || !done) begin
                failures++;
                $display("FAIL soak_timeout t=%0d got accepted=%b completed=%b exp 1/1", t, ok, done);
                break;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL soak_summary got bad=%0d exp bad=0", bad);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive_pps('{default: '0});
        test_reset();
        test_basic();
        test_negative();
        test_sign_ext();
        test_backpressure();
        test_reset_mid();
        test_soak();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth2_pp_accum.md
# booth2_pp_accum

Sequential partial-product accumulator for the radix-4 Booth 16×16 multiplier. It accepts the eight 17-bit signed partial products produced by the Booth partial-product generator in a single valid/ready handshake. It then sums them one per cycle, each at weight 4^(i-1), into a 32-bit signed product. It is the low-area, multi-cycle alternative to the Wallace-tree reduction and sits directly downstream of the partial-product generator.

## Interface
- PP_NUM, 8, number of partial products
- PP_W, 17, partial-product width (two's complement)
- PROD_W, 32, product width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  PP1..PP8 valid
- in_ready  out  1  block can accept a new set
- PP1..PP8  in  17 each  partial products; PPi carries weight 4^(i-1)
- out_valid  out  1  out_product valid
- out_ready  in  1  downstream accepts product
- out_product  out  32  signed product, i.e. sum of sign-extended PPi << 2(i-1), mod 2^32

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid, register all eight PPs into pp_reg[0..7], clear acc, clear idx, and go to ACC.
  - ACC: each cycle, acc <= acc + (sext32(pp_reg[idx]) << 2·idx) and idx <= idx+1. When idx==7, go to DONE.
  - DONE: out_valid=1 and out_product=acc. On out_ready, go to IDLE.
- in_ready is 1 only in IDLE. in_valid in ACC or DONE is ignored, with no capture and no error.
- Arithmetic:
  - Each PP is sign-extended from bit 16 to 32 bits, then shifted.
  - Additions wrap modulo 2^32; no overflow flag.
  - PP7 and PP8 shifted terms are truncated to 32 bits before addition.
- Captured PPs are held in pp_reg. The PP1..PP8 inputs may change freely after the accept edge.
- out_product holds its value while out_valid=1 and out_ready=0.
- Reset values: state=IDLE, idx=0, acc=0, pp_reg=0, out_valid=0, out_product=0. in_ready=0 while rst=1.

## Timing
- Accept edge E0 is the rising edge where in_valid && in_ready.
- ACC occupies edges E1..E8, one PP per edge.
- out_valid rises after E8. Latency is 8 cycles from the accept edge to out_valid high.
- Output handshake edge where out_valid && out_ready returns the FSM to IDLE. in_ready is 1 in the following cycle.
- Minimum initiation interval: 10 cycles (1 accept + 8 ACC + 1 DONE with out_ready=1).
- Simultaneous events:
  - in_valid asserted during DONE with out_ready=1 is not accepted that cycle; it must be held until in_ready=1.
  - rst wins over every handshake.
- Reset mid-operation (ACC or DONE): the in-flight result is discarded. Next cycle out_valid=0 and acc=0; in_ready=1 once rst is deasserted.

## Structure
- Shared package booth2_pkg holds PP_NUM, PP_W, PROD_W and the state enum {IDLE, ACC, DONE}. The encoder side and the Wallace path use the same constants.
- One sub-module, booth2_pp_align, is combinational. It performs sign-extend and shift: inputs pp[16:0] and idx[2:0], output term[31:0] = sext32(pp) << 2·idx. The top instantiates it once, with its input selected from pp_reg by idx.
- Width of idx is 3 bits; it saturates by the FSM transition, not by wrap.

## Test plan
- A=3, B=5 (PP1=17'h00003, PP2=17'h00003, others 0), out_ready=1 → out_valid 8 cycles after accept, out_product=32'h0000000F, in_ready=1 the next cycle.
- A=-1, B=2 (PP1=17'h00002, PP2=17'h1FFFF, others 0) → out_product=32'hFFFFFFFE.
- All PPi=17'h10000 → out_product=32'hAAAB0000, checking sign extension and the truncated high terms.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid and toggle in_valid/PP inputs → out_product stable, in_ready=0, no second capture. Raise out_ready → one handshake, then in_ready=1.
- Reset mid-ACC: assert rst for 1 cycle at idx=4 → out_valid=0 and in_ready=1 after release. A following A=3, B=5 transaction yields 32'h0000000F.
- Random soak: 1000 random (A,B) pairs, with PPs from a reference Booth encoding and random out_ready stalls → out_product == A·B (signed, 32-bit) for every transaction, in order.
